// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 constants, FSM state encoding, affine point type and mod-p helpers.
// The helpers are plain combinational functions used by the affine point units.
package secp256k1_pkg;

  localparam int COORD_W = 256;

  localparam logic [255:0] P_MOD   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] N_ORDER = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam logic [255:0] GX      = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] GY      = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

  typedef enum logic [1:0] {IDLE, DBL, ADD, DONE} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               inf;
  } point_t;

  localparam point_t POINT_INF = '{x: '0, y: '0, inf: 1'b1};

  function automatic logic [255:0] mod_add(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P_MOD}) s = s - {1'b0, P_MOD};
    return s[255:0];
  endfunction

  function automatic logic [255:0] mod_sub(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] d;
    d = {1'b0, a} + {1'b0, P_MOD} - {1'b0, b};
    if (d >= {1'b0, P_MOD}) d = d - {1'b0, P_MOD};
    return d[255:0];
  endfunction

  // 2^256 == 2^32 + 977 (mod p): fold the high half twice with shifts, then trim.
  function automatic logic [255:0] mod_mul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] r;
    logic [511:0] hi;
    r = {256'b0, a} * {256'b0, b};
    for (int pass = 0; pass < 2; pass++) begin
      hi = {256'b0, r[511:256]};
      r  = {256'b0, r[255:0]} + (hi << 32) + (hi << 10) + hi - (hi << 5) - (hi << 4);
    end
    if (r >= {256'b0, P_MOD}) r = r - {256'b0, P_MOD};
    if (r >= {256'b0, P_MOD}) r = r - {256'b0, P_MOD};
    return r[255:0];
  endfunction

  // Fermat inverse a^(p-2); an input of 0 yields 0, which callers never select.
  function automatic logic [255:0] mod_inv(input logic [255:0] a);
    logic [255:0] e;
    logic [255:0] r;
    e = P_MOD - 256'd2;
    r = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = mod_mul(r, r);
      if (e[i]) r = mod_mul(r, a);
    end
    return r;
  endfunction

endpackage

// File: rtl/ec_inf_select.sv
// Picks the correct double/add result given infinity operands, equal x and y == 0,
// so the scalar-multiply FSM never compares coordinates itself.
module ec_inf_select
  import secp256k1_pkg::*;
(
  input  logic [COORD_W-1:0] acc_x,
  input  logic [COORD_W-1:0] acc_y,
  input  logic               acc_inf,
  input  logic [COORD_W-1:0] base_x,
  input  logic [COORD_W-1:0] base_y,
  input  logic [COORD_W-1:0] dbl_x,
  input  logic [COORD_W-1:0] dbl_y,
  input  logic [COORD_W-1:0] add_x,
  input  logic [COORD_W-1:0] add_y,
  output logic [COORD_W-1:0] dbl_rx,
  output logic [COORD_W-1:0] dbl_ry,
  output logic               dbl_rinf,
  output logic [COORD_W-1:0] add_rx,
  output logic [COORD_W-1:0] add_ry,
  output logic               add_rinf
);

  logic dbl_to_inf;
  logic same_x;
  logic same_y;

  assign dbl_to_inf = acc_inf || (acc_y == '0);
  assign same_x     = (acc_x == base_x);
  assign same_y     = (acc_y == base_y);

  always_comb begin
    dbl_rx   = dbl_to_inf ? '0 : dbl_x;
    dbl_ry   = dbl_to_inf ? '0 : dbl_y;
    dbl_rinf = dbl_to_inf;

    add_rx   = add_x;
    add_ry   = add_y;
    add_rinf = 1'b0;
    if (acc_inf) begin
      add_rx = base_x;
      add_ry = base_y;
    end else if (same_x && same_y) begin
      // acc equals P, and the doubler is already fed acc, so its result is 2P
      add_rx   = dbl_rx;
      add_ry   = dbl_ry;
      add_rinf = dbl_rinf;
    end else if (same_x) begin
      add_rx   = '0;
      add_ry   = '0;
      add_rinf = 1'b1;
    end
  end

endmodule

// File: rtl/point_add.sv
// Combinational affine addition of two distinct-x points; equal x is handled by the caller.
module point_add
  import secp256k1_pkg::*;
(
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  output logic [COORD_W-1:0] rx,
  output logic [COORD_W-1:0] ry
);

  logic [COORD_W-1:0] lam;

  always_comb begin
    lam = mod_mul(mod_sub(y2, y1), mod_inv(mod_sub(x2, x1)));
    rx  = mod_sub(mod_sub(mod_mul(lam, lam), x1), x2);
    ry  = mod_sub(mod_mul(lam, mod_sub(x1, rx)), y1);
  end

endmodule

// File: rtl/point_double.sv
// Combinational affine doubling on secp256k1 (a = 0); y == 0 is handled by the caller.
module point_double
  import secp256k1_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] rx,
  output logic [COORD_W-1:0] ry
);

  logic [COORD_W-1:0] xx;
  logic [COORD_W-1:0] lam;

  always_comb begin
    xx  = mod_mul(x, x);
    lam = mod_mul(mod_add(mod_add(xx, xx), xx), mod_inv(mod_add(y, y)));
    rx  = mod_sub(mod_mul(lam, lam), mod_add(x, x));
    ry  = mod_sub(mod_mul(lam, mod_sub(x, rx)), y);
  end

endmodule

// File: rtl/ec_scalar_mult.sv
// Sequential secp256k1 scalar multiplier Q = k*P, left-to-right double-and-add.
// Define SCALAR_MULT_CONST_TIME_EN to visit ADD on every bit (fixed 2*KW+1 latency).
module ec_scalar_mult
  import secp256k1_pkg::*;
#(
  parameter int KW = 256,
  parameter int CW = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic [CW-1:0] px,
  input  logic [CW-1:0] py,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] qx,
  output logic [CW-1:0] qy,
  output logic          q_inf
);

  localparam int IW = $clog2(KW);

`ifdef SCALAR_MULT_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  state_t        state_reg, state_next;
  logic [KW-1:0] k_reg, k_next;
  logic [IW-1:0] idx_reg, idx_next;
  point_t        acc_reg, acc_next;
  logic [CW-1:0] base_x_reg, base_x_next;
  logic [CW-1:0] base_y_reg, base_y_next;
  logic [CW-1:0] qx_reg, qx_next;
  logic [CW-1:0] qy_reg, qy_next;
  logic          q_inf_reg, q_inf_next;

  logic [CW-1:0] dbl_x, dbl_y, add_x, add_y;
  point_t        dbl_sel, add_sel;
  logic          last_bit;

  point_double u_double (
    .x  (acc_reg.x),
    .y  (acc_reg.y),
    .rx (dbl_x),
    .ry (dbl_y)
  );

  point_add u_add (
    .x1 (acc_reg.x),
    .y1 (acc_reg.y),
    .x2 (base_x_reg),
    .y2 (base_y_reg),
    .rx (add_x),
    .ry (add_y)
  );

  ec_inf_select u_select (
    .acc_x    (acc_reg.x),
    .acc_y    (acc_reg.y),
    .acc_inf  (acc_reg.inf),
    .base_x   (base_x_reg),
    .base_y   (base_y_reg),
    .dbl_x    (dbl_x),
    .dbl_y    (dbl_y),
    .add_x    (add_x),
    .add_y    (add_y),
    .dbl_rx   (dbl_sel.x),
    .dbl_ry   (dbl_sel.y),
    .dbl_rinf (dbl_sel.inf),
    .add_rx   (add_sel.x),
    .add_ry   (add_sel.y),
    .add_rinf (add_sel.inf)
  );

  assign last_bit = (idx_reg == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      k_reg      <= '0;
      idx_reg    <= '0;
      acc_reg    <= '0;
      base_x_reg <= '0;
      base_y_reg <= '0;
      qx_reg     <= '0;
      qy_reg     <= '0;
      q_inf_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      k_reg      <= k_next;
      idx_reg    <= idx_next;
      acc_reg    <= acc_next;
      base_x_reg <= base_x_next;
      base_y_reg <= base_y_next;
      qx_reg     <= qx_next;
      qy_reg     <= qy_next;
      q_inf_reg  <= q_inf_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    idx_next    = idx_reg;
    acc_next    = acc_reg;
    base_x_next = base_x_reg;
    base_y_next = base_y_reg;
    qx_next     = qx_reg;
    qy_next     = qy_reg;
    q_inf_next  = q_inf_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          k_next      = k;
          base_x_next = px;
          base_y_next = py;
          acc_next    = POINT_INF;
          idx_next    = IW'(KW - 1);
          state_next  = DBL;
        end
      end
      DBL: begin
        acc_next = dbl_sel;
        if (CONST_TIME || k_reg[idx_reg]) begin
          state_next = ADD;
        end else if (last_bit) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg - 1'b1;
          state_next = DBL;
        end
      end
      ADD: begin
        // On a zero bit (constant-time only) the sum is evaluated but dropped
        if (k_reg[idx_reg]) acc_next = add_sel;
        if (last_bit) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg - 1'b1;
          state_next = DBL;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Result registers load on entry to DONE so they are valid alongside the pulse
    if (state_next == DONE) begin
      qx_next    = acc_next.x;
      qy_next    = acc_next.y;
      q_inf_next = acc_next.inf;
    end
  end

  assign busy  = (state_reg == DBL) || (state_reg == ADD);
  assign done  = (state_reg == DONE);
  assign qx    = qx_reg;
  assign qy    = qy_reg;
  assign q_inf = q_inf_reg;

endmodule
